// File: rtl/mult_share_arb.sv
// Round-robin arbiter in front of one shared shift-add multiplier.
// One operand bit per clock; the result is returned tagged with the winner's ID.
module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_result,
  output logic            busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    acc;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  id_reg;
  logic [IDW-1:0]  rr_last;
  logic [IDW-1:0]  winner;
  logic            found;
  logic [NREQ-1:0] grant;
  logic            accept;

  // Search starts just after the last winner so every holder is reached.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(int'(rr_last) + k) % NREQ]) begin
        found  = 1'b1;
        winner = IDW'((int'(rr_last) + k) % NREQ);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && found)
      grant = NREQ'(1) << winner;
  end

  assign req_ready  = grant;
  assign accept     = |(req_valid & grant);
  assign rsp_valid  = (state == DONE);
  assign rsp_id     = id_reg;
  assign rsp_result = acc;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      id_reg  <= '0;
      rr_last <= IDW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg   <= req_a[int'(winner)*W +: W];
            b_reg   <= req_b[int'(winner)*W +: W];
            acc     <= '0;
            cnt     <= '0;
            id_reg  <= winner;
            rr_last <= winner;
            state   <= RUN;
          end
        end
        RUN: begin
          if (b_reg[0])
            acc <= acc + a_reg;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST)
            state <= DONE;
        end
        DONE: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
